i2c_slave: RTL
==============

# i2c_slave

I2C target (slave) endpoint that sits directly downstream of the I2C master on the shared SCL/SDA bus and consumes the transactions it produces. It oversamples SCL/SDA in the system clock domain, detects START/STOP, matches a fixed 7-bit address, and ACKs. On writes it delivers each received byte on a valid-pulse port. On reads it shifts out bytes supplied by the local logic.

## Interface
- `OWN_ADDR`, default `7'h2A`: 7-bit address this target responds to.
- `clk` input, 1: system clock; must be ≥ 16× the SCL frequency.
- `rst_n` input, 1: asynchronous, active-low reset.
- `scl` input, 1: bus clock; this target never stretches SCL.
- `sda` inout, 1: bus data; this block only drives `0` or `z`.
- `rx_data` output, 8: last byte written by the master.
- `rx_valid` output, 1: one-`clk` pulse when `rx_data` is updated.
- `tx_data` input, 8: byte to return on reads; sampled when `tx_req` pulses.
- `tx_req` output, 1: one-`clk` pulse; `tx_data` is captured on that same cycle.
- `addr_hit` output, 1: one-`clk` pulse on address match; qualifies `rw`.
- `rw` output, 1: R/W bit of the current transaction (1 = read).
- `busy` output, 1: high from an address match until STOP or a non-matching START.

## Operation
- **Input conditioning:** `scl` and `sda` each pass through a 2-flop synchronizer.
- **Edge and condition detection:**
  - SCL rise/fall is detected by comparing the current and previous synchronized samples.
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
- **States:** `IDLE`, `ADDR`, `ADDR_ACK`, `WR_DATA`, `WR_ACK`, `RD_DATA`, `RD_ACK`, `WAIT_STOP`.
- **Global transitions, from any state:**
  - START → `ADDR`, bit counter = 7 (repeated START included).
  - STOP → `IDLE`, SDA released.
- **`ADDR`:**
  - Shift SDA in on each SCL rise, MSB first.
  - After the 8th bit, compare bits[7:1] with `OWN_ADDR`.
  - Match: pulse `addr_hit`, latch `rw` = bit0, go to `ADDR_ACK`.
  - Mismatch: go to `IDLE` (no ACK) and wait for the next START.
- **`ADDR_ACK`:**
  - Drive SDA=0 from the next SCL fall until the following SCL fall.
  - Then go to `WR_DATA` if `rw`=0.
  - If `rw`=1: pulse `tx_req`, load `tx_data` into the shift register, drive its MSB, go to `RD_DATA`.
- **`WR_DATA`:** shift in 8 bits on SCL rises, then go to `WR_ACK`.
- **`WR_ACK`:**
  - On the next SCL fall: update `rx_data`, pulse `rx_valid`, drive SDA=0.
  - On the following SCL fall: release SDA, return to `WR_DATA`.
  - Unlimited bytes per transaction.
- **`RD_DATA`:**
  - On each SCL fall drive the next bit: shift-register bit=0 → SDA=0, bit=1 → release.
  - After the 8th bit's fall, release SDA and go to `RD_ACK`.
- **`RD_ACK`:** sample SDA on the SCL rise.
  - ACK (0): at the next SCL fall, pulse `tx_req`, load `tx_data`, drive MSB, go to `RD_DATA`.
  - NACK (1): go to `WAIT_STOP`.
- **`WAIT_STOP`:** SDA released; only START or STOP leave this state.
- **Bit counter:** 3 bits, counts down 7→0. Reloaded to 7 on START and on every byte boundary.

## Timing
- **Reset values:**
  - State `IDLE`, SDA released (`z`).
  - `rx_data`=0; `rx_valid`, `tx_req`, `addr_hit`, `rw`, `busy` = 0.
  - Both synchronizer flops preset to 1.
- **Input latency:** 2 `clk` synchronizer + 1 `clk` edge detect = 3 `clk` from a pin change to the internal event.
- **SDA drive changes:** occur on the `clk` after a detected SCL fall, so SDA is always stable before the next SCL rise.
- **SDA release on STOP:** within 1 `clk` of STOP detection.
- **SCL high minimum:** ≥ 4 `clk` for reliable sampling.
- **Simultaneous events:** START/STOP detection has priority over SCL-edge processing in the same `clk`.
- **Reset mid-operation:** `rst_n` low releases SDA immediately (asynchronously) and returns to `IDLE`. After release, the block ignores bus activity until the next START.

## Configuration
- `I2C_SLAVE_GLITCH_FILTER_EN`
  - **Defined:** a 3-sample majority filter follows each synchronizer. This suppresses 1-`clk` glitches and adds 2 `clk` to input latency (5 total). The SCL high minimum rises to 6 `clk`.
  - **Undefined:** no filter; latency is as stated above.

## Test plan
- **Reset:** hold `rst_n`=0 while the master drives traffic → SDA stays `z`, all outputs 0, state `IDLE`.
- **Single write:** master writes address 0x2A, W, data 0xA5 → slave ACKs the address and the data; `addr_hit`=1 pulse with `rw`=0; exactly one `rx_valid` pulse with `rx_data`=0xA5; `busy` falls at STOP.
- **Address mismatch:** master addresses 0x2B → SDA never driven, master sees NACK, no `addr_hit` or `rx_valid`, `busy` stays 0.
- **Single read:** `tx_data`=0x3C, master reads 0x2A then NACKs → one `tx_req` pulse, bits 0,0,1,1,1,1,0,0 seen on SDA, slave releases SDA in `WAIT_STOP`.
- **Multi-byte read:** master ACKs the first byte, `tx_data` changes 0x3C→0x81 → second `tx_req` pulse, second byte reads 0x81.
- **Repeated START:** START mid-`WR_DATA`, then address 0x2A, R → returns to `ADDR`, ACKs, `rw`=1.
- **Reset mid-drive:** assert `rst_n` while SDA is driven low during an ACK → SDA released within 0 `clk` (asynchronous).

Source files
------------

// File: rtl/i2c_slave_if.sv
// i2c_slave_if: open-drain I2C bus pins plus the local byte-streaming handshake of the target.
// sda is the wired-AND bus level; sda_oe=1 means the target pulls SDA low, 0 means released (z).
interface i2c_slave_if;
    logic       scl;
    logic       sda_m;
    logic       sda_oe;
    logic       sda;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       addr_hit;
    logic       rw;
    logic       busy;
    assign sda = sda_m & ~sda_oe;
    modport slave (
        input  scl, sda, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, addr_hit, rw, busy
    );
    modport master (
        output scl, sda_m, tx_data,
        input  sda, sda_oe, rx_data, rx_valid, tx_req, addr_hit, rw, busy
    );
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target that matches OWN_ADDR, ACKs, delivers written bytes and serves read bytes.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter after each synchronizer.
module i2c_slave #(
    parameter logic [6:0] OWN_ADDR = 7'h2A
) (
    input logic        clk,
    input logic        rst_n,
    i2c_slave_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP} state_t;
    state_t     state, state_n;
    logic [1:0] scl_s, sda_s;
    logic       scl_f, sda_f, scl_p, sda_p;
    logic       rise, fall, start, stop;
    logic [2:0] cnt, cnt_n;
    logic [7:0] sh, sh_n, rx_data_n;
    logic       oe_n, rw_n, busy_n, rx_valid_n, tx_req_n, addr_hit_n;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            scl_s <= 2'b11;
            sda_s <= 2'b11;
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_s <= {scl_s[0], bus.scl};
            sda_s <= {sda_s[0], bus.sda};
            scl_p <= scl_f;
            sda_p <= sda_f;
        end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] scl_h, sda_h;
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            scl_h <= 3'b111;
            sda_h <= 3'b111;
        end else begin
            scl_h <= {scl_h[1:0], scl_s[1]};
            sda_h <= {sda_h[1:0], sda_s[1]};
        end
    assign scl_f = maj3(scl_h);
    assign sda_f = maj3(sda_h);
`else
    assign scl_f = scl_s[1];
    assign sda_f = sda_s[1];
`endif

    assign rise  = scl_f & ~scl_p;
    assign fall  = ~scl_f & scl_p;
    assign start = scl_f & scl_p & sda_p & ~sda_f;
    assign stop  = scl_f & scl_p & ~sda_p & sda_f;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 3'd7;
            sh           <= '0;
            bus.sda_oe   <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            bus.tx_req   <= 1'b0;
            bus.addr_hit <= 1'b0;
            bus.rw       <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            sh           <= sh_n;
            bus.sda_oe   <= oe_n;
            bus.rx_data  <= rx_data_n;
            bus.rx_valid <= rx_valid_n;
            bus.tx_req   <= tx_req_n;
            bus.addr_hit <= addr_hit_n;
            bus.rw       <= rw_n;
            bus.busy     <= busy_n;
        end

    // The counter wraps 0 -> 7 on its own, which is the reload at every byte boundary.
    // In the ACK states sda_oe doubles as the phase flag: first fall drives, second fall releases.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        sh_n       = sh;
        oe_n       = bus.sda_oe;
        rx_data_n  = bus.rx_data;
        rw_n       = bus.rw;
        busy_n     = bus.busy;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;
        addr_hit_n = 1'b0;
        if (start) begin
            state_n = ADDR;
            cnt_n   = 3'd7;
            oe_n    = 1'b0;
        end else if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                ADDR: if (rise) begin
                    sh_n  = {sh[6:0], sda_f};
                    cnt_n = cnt - 3'd1;
                    if (cnt == 3'd0) begin
                        state_n    = (sh[6:0] == OWN_ADDR) ? ADDR_ACK : IDLE;
                        busy_n     = sh[6:0] == OWN_ADDR;
                        addr_hit_n = sh[6:0] == OWN_ADDR;
                        rw_n       = (sh[6:0] == OWN_ADDR) ? sda_f : bus.rw;
                    end
                end
                ADDR_ACK: if (fall) begin
                    if (!bus.sda_oe) oe_n = 1'b1;
                    else if (bus.rw) begin
                        tx_req_n = 1'b1;
                        sh_n     = bus.tx_data;
                        oe_n     = ~bus.tx_data[7];
                        state_n  = RD_DATA;
                    end else begin
                        oe_n    = 1'b0;
                        state_n = WR_DATA;
                    end
                end
                WR_DATA: if (rise) begin
                    sh_n    = {sh[6:0], sda_f};
                    cnt_n   = cnt - 3'd1;
                    state_n = (cnt == 3'd0) ? WR_ACK : WR_DATA;
                end
                WR_ACK: if (fall) begin
                    if (!bus.sda_oe) begin
                        rx_data_n  = sh;
                        rx_valid_n = 1'b1;
                        oe_n       = 1'b1;
                    end else begin
                        oe_n    = 1'b0;
                        state_n = WR_DATA;
                    end
                end
                RD_DATA: if (fall) begin
                    cnt_n   = cnt - 3'd1;
                    sh_n    = {sh[6:0], 1'b0};
                    oe_n    = (cnt == 3'd0) ? 1'b0 : ~sh[6];
                    state_n = (cnt == 3'd0) ? RD_ACK : RD_DATA;
                end
                RD_ACK:
                    if (rise && sda_f) state_n = WAIT_STOP;
                    else if (fall) begin
                        tx_req_n = 1'b1;
                        sh_n     = bus.tx_data;
                        oe_n     = ~bus.tx_data[7];
                        state_n  = RD_DATA;
                    end
                IDLE, WAIT_STOP: oe_n = 1'b0;
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
